// File: rtl/bus_wr_slave.sv
// Responder for the active-low cs/wr parallel write bus: qualifies a strobe held
// stable for MIN_CYC clocks and commits one word per strobe into a register file.
module bus_wr_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
   parameter int          REG_NUM   = 64,
   parameter int          MIN_CYC   = 2,
   localparam int         IDX_W     = $clog2(REG_NUM),
   localparam int         CNT_W     = $clog2(MIN_CYC + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_cs,
   input  logic             i_wr,
   input  logic [31:0]      i_addr,
   input  logic [31:0]      i_data,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic [31:0]      o_rd_data,
   output logic             o_wr_valid,
   output logic [31:0]      o_wr_addr,
   output logic [31:0]      o_wr_data,
   output logic             o_err,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_CYC);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_lat_addr;
   logic [31:0]       r_lat_data;
   logic              r_wr_valid;
   logic              r_err;
   logic [31:0]       r_wr_addr;
   logic [31:0]       r_wr_data;
   logic [31:0]       r_regs [REG_NUM];

   logic              w_strobe;
   logic              w_stable;
   logic              w_hit;
   logic              w_commit;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [IDX_W-1:0]  w_idx;

   assign w_strobe  = !i_cs && !i_wr;
   assign w_stable  = (i_addr == r_lat_addr) && (i_data == r_lat_data);
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

   // A commit only ever happens while the bus equals the latch, so the live
   // bus values serve as the commit source in both the IDLE and ACTIVE cases.
   assign w_hit = ((i_addr & ADDR_MASK) == BASE_ADDR);
   assign w_idx = i_addr[IDX_W+1:2];

   always_comb begin
      w_commit = 1'b0;
      case (r_state)
         S_IDLE:   w_commit = w_strobe && (MIN_CYC == 1);
         S_ACTIVE: w_commit = w_strobe && w_stable && (w_cnt_inc == CNT_MAX);
         default:  w_commit = 1'b0;
      endcase
   end

   // Reset lands in HOLD so a strobe already low at release is never taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_HOLD;
         r_cnt      <= '0;
         r_lat_addr <= '0;
         r_lat_data <= '0;
         r_wr_valid <= 1'b0;
         r_err      <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_wr_valid <= 1'b0;
         r_err      <= 1'b0;
         if (r_state == S_IDLE && w_strobe) begin
            r_lat_addr <= i_addr;
            r_lat_data <= i_data;
            r_cnt      <= CNT_W'(1);
         end
         if (w_commit) begin
            r_state <= S_HOLD;
            if (r_state == S_ACTIVE) r_cnt <= w_cnt_inc;
            if (w_hit) begin
               r_wr_valid <= 1'b1;
               r_wr_addr  <= i_addr;
               r_wr_data  <= i_data;
            end else begin
               r_err <= 1'b1;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_strobe) r_state <= S_ACTIVE;
               end
               S_ACTIVE: begin
                  if (!w_strobe) begin
                     r_state <= S_IDLE;
                  end else if (!w_stable) begin
                     r_err   <= 1'b1;
                     r_state <= S_HOLD;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
               default: begin
                  if (!w_strobe) r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
      end else if (w_commit && w_hit) begin
         r_regs[w_idx] <= i_data;
      end
   end

   assign o_rd_data  = r_regs[i_rd_idx];
   assign o_wr_valid = r_wr_valid;
   assign o_wr_addr  = r_wr_addr;
   assign o_wr_data  = r_wr_data;
   assign o_err      = r_err;
   assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_wr_slave.sv
// Bench for bus_wr_slave: transaction-level model of strobe outcomes and a
// shadow register file, compared against pulses, held outputs and read port.
module tb_bus_wr_slave;

   localparam logic [31:0] BASE    = 32'h1100_0000;
   localparam logic [31:0] MASK    = 32'hFFFF_FF00;
   localparam int          MIN_CYC = 2;

   logic        clk;
   logic        rst_n;
   logic        i_cs;
   logic        i_wr;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic [5:0]  i_rd_idx;
   logic [31:0] o_rd_data;
   logic        o_wr_valid;
   logic [31:0] o_wr_addr;
   logic [31:0] o_wr_data;
   logic        o_err;
   logic        o_busy;

   int          errors;
   int          checks;
   logic [31:0] m_regs [64];
   logic [31:0] m_wr_addr;
   logic [31:0] m_wr_data;

   bus_wr_slave dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_cs       (i_cs),
      .i_wr       (i_wr),
      .i_addr     (i_addr),
      .i_data     (i_data),
      .i_rd_idx   (i_rd_idx),
      .o_rd_data  (o_rd_data),
      .o_wr_valid (o_wr_valid),
      .o_wr_addr  (o_wr_addr),
      .o_wr_data  (o_wr_data),
      .o_err      (o_err),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare every register through the read port, then realign to a negedge.
   task automatic check_regs(input string name);
      for (int i = 0; i < 64; i++) begin
         i_rd_idx = 6'(i);
         #1;
         checks++;
         if (o_rd_data !== m_regs[i]) begin
            errors++;
            $display("FAIL %s regs[%0d]: got %h want %h", name, i, o_rd_data, m_regs[i]);
         end
      end
      @(negedge clk);
   endtask

   // One strobe of len clocks then post idle clocks. kind: 0 stable,
   // 1 data changes at chg_at, 2 addr changes at chg_at, 3 cs low with wr high.
   // Entered just after a negedge; outputs sampled at each following negedge.
   task automatic drive_strobe(input logic [31:0] a, input logic [31:0] d, input int len,
                               input int kind, input int chg_at, input int post,
                               input string name);
      bit          exp_wr;
      bit          exp_err;
      int          nv;
      int          ne;
      logic [5:0]  idx;
      logic [31:0] old_val;
      logic [31:0] prev_rd;
      exp_wr  = 0;
      exp_err = 0;
      if (kind == 3) begin
         exp_wr = 0;
      end else if ((kind == 1 || kind == 2) && chg_at >= 1 && chg_at < MIN_CYC && chg_at < len) begin
         exp_err = 1;
      end else if (len >= MIN_CYC) begin
         if ((a & MASK) == BASE) exp_wr = 1;
         else exp_err = 1;
      end
      idx      = a[7:2];
      old_val  = m_regs[idx];
      i_rd_idx = idx;
      prev_rd  = o_rd_data;
      nv = 0;
      ne = 0;
      for (int k = 0; k < len + post; k++) begin
         if (k < len) begin
            i_cs   = 1'b0;
            i_wr   = (kind == 3);
            i_addr = (kind == 2 && k >= chg_at) ? a + 32'd4 : a;
            i_data = (kind == 1 && k >= chg_at) ? d + 32'd1 : d;
         end else begin
            i_cs = 1'b1;
            i_wr = 1'b1;
         end
         @(negedge clk);
         if (o_wr_valid === 1'b1) begin
            nv++;
            if (exp_wr) begin
               checks++;
               if (o_rd_data !== d) begin
                  errors++;
                  $display("FAIL %s rd_after_commit: got %h want %h", name, o_rd_data, d);
               end
               if (k >= 1) begin
                  checks++;
                  if (prev_rd !== old_val) begin
                     errors++;
                     $display("FAIL %s rd_before_commit: got %h want %h", name, prev_rd, old_val);
                  end
               end
            end
         end
         if (o_err === 1'b1) ne++;
         if (k == len - 1) begin
            checks++;
            if (o_busy !== (kind != 3)) begin
               errors++;
               $display("FAIL %s busy_during: got %b want %b", name, o_busy, (kind != 3));
            end
         end
         prev_rd = o_rd_data;
      end
      if (exp_wr) begin
         m_regs[idx] = d;
         m_wr_addr   = a;
         m_wr_data   = d;
      end
      checks++;
      if (nv != int'(exp_wr)) begin
         errors++;
         $display("FAIL %s wr_valid_cycles: got %0d want %0d", name, nv, exp_wr);
      end
      checks++;
      if (ne != int'(exp_err)) begin
         errors++;
         $display("FAIL %s err_cycles: got %0d want %0d", name, ne, exp_err);
      end
      checks++;
      if (o_wr_addr !== m_wr_addr) begin
         errors++;
         $display("FAIL %s wr_addr: got %h want %h", name, o_wr_addr, m_wr_addr);
      end
      checks++;
      if (o_wr_data !== m_wr_data) begin
         errors++;
         $display("FAIL %s wr_data: got %h want %h", name, o_wr_data, m_wr_data);
      end
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_after: got %b want 0", name, o_busy);
      end
      checks++;
      if (o_rd_data !== m_regs[idx]) begin
         errors++;
         $display("FAIL %s rd_final: got %h want %h", name, o_rd_data, m_regs[idx]);
      end
      $display("txn %s addr=%h data=%h len=%0d kind=%0d chg=%0d valid=%0d err=%0d",
               name, a, d, len, kind, chg_at, nv, ne);
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      i_cs     = 1'b1;
      i_wr     = 1'b1;
      i_addr   = '0;
      i_data   = '0;
      i_rd_idx = '0;
      for (int i = 0; i < 64; i++) m_regs[i] = '0;
      m_wr_addr = '0;
      m_wr_data = '0;
      #11;
      checks++;
      if (o_busy !== 1'b1 || o_wr_valid !== 1'b0 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got busy=%b valid=%b err=%b want 1 0 0", o_busy, o_wr_valid, o_err);
      end
      checks++;
      if (o_wr_addr !== 32'h0 || o_wr_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_held: got %h %h want 0 0", o_wr_addr, o_wr_data);
      end
      #9 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: got %b want 0", o_busy);
      end
      check_regs("reset");
   endtask

   task automatic test_basic();
      drive_strobe(32'h1100_008a, 32'h1111_3000, 3, 0, 0, 2, "basic");
      drive_strobe(32'h1100_00fc, 32'hA5A5_0001, 2, 0, 0, 2, "basic_top");
      check_regs("basic");
   endtask

   task automatic test_glitch();
      drive_strobe(32'h1100_0020, 32'h0BAD_0001, 1, 0, 0, 2, "glitch");
      drive_strobe(32'h1100_0024, 32'h0BAD_0002, 3, 3, 0, 2, "cs_only");
      check_regs("glitch");
   endtask

   task automatic test_miss();
      drive_strobe(32'h2200_0010, 32'hDEAD_BEEF, 3, 0, 0, 2, "miss");
      check_regs("miss");
   endtask

   task automatic test_unstable();
      drive_strobe(32'h1100_0030, 32'h0000_0001, 4, 1, 1, 2, "unstable_data");
      drive_strobe(32'h1100_0034, 32'h0000_0077, 3, 2, 1, 2, "unstable_addr");
      drive_strobe(32'h1100_0038, 32'h0000_0099, 4, 1, 3, 2, "late_change");
      check_regs("unstable");
   endtask

   task automatic test_back_to_back();
      drive_strobe(32'h1100_0008, 32'hCAFE_0002, 10, 0, 0, 1, "b2b_first");
      drive_strobe(32'h1100_0004, 32'hCAFE_0001, 3, 0, 0, 2, "b2b_second");
      check_regs("back_to_back");
   endtask

   task automatic test_reset_mid();
      int nv;
      int ne;
      i_cs     = 1'b0;
      i_wr     = 1'b0;
      i_addr   = 32'h1100_0008;
      i_data   = 32'h7777_0000;
      i_rd_idx = 6'd2;
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 64; i++) m_regs[i] = '0;
      m_wr_addr = '0;
      m_wr_data = '0;
      #1;
      checks++;
      if (o_rd_data !== 32'h0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_async: got rd=%h busy=%b want 0 1", o_rd_data, o_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      nv = 0;
      ne = 0;
      repeat (4) begin
         @(negedge clk);
         if (o_wr_valid === 1'b1) nv++;
         if (o_err === 1'b1) ne++;
      end
      checks++;
      if (nv != 0 || ne != 0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_held: got valid=%0d err=%0d busy=%b want 0 0 1", nv, ne, o_busy);
      end
      i_cs = 1'b1;
      i_wr = 1'b1;
      @(negedge clk);
      drive_strobe(32'h1100_0008, 32'h7777_0001, 3, 0, 0, 2, "after_reset");
      check_regs("reset_mid");
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] d;
      int          len;
      int          kind;
      int          chg;
      int          post;
      for (int n = 0; n < 40; n++) begin
         a    = ($urandom_range(0, 3) == 0) ? $urandom : (BASE | 32'($urandom_range(0, 255)));
         d    = $urandom;
         len  = $urandom_range(1, 5);
         kind = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
         chg  = $urandom_range(1, len);
         post = $urandom_range(1, 3);
         drive_strobe(a, d, len, kind, chg, post, "random");
      end
      check_regs("random");
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_basic();
      test_glitch();
      test_miss();
      test_unstable();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
